// File: rtl/multu_hilo_pkg.sv
// rtl/multu_hilo_pkg.sv - shared ALU operation codes and multiply FSM state encoding
package multu_hilo_pkg;

    // Operation codes produced by the ALU control unit
    localparam logic [5:0] ALU_sll   = 6'b000000;
    localparam logic [5:0] ALU_add   = 6'b100000;
    localparam logic [5:0] ALU_sub   = 6'b100010;
    localparam logic [5:0] ALU_and   = 6'b100100;
    localparam logic [5:0] ALU_or    = 6'b100101;
    localparam logic [5:0] ALU_slt   = 6'b101010;
    localparam logic [5:0] ALU_multu = 6'b011001;
    localparam logic [5:0] ALU_mfhi  = 6'b010000;
    localparam logic [5:0] ALU_mflo  = 6'b010010;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // True for the ops that touch HI/LO and therefore must wait on a multiply
    function automatic logic is_hilo_op(input logic [5:0] op);
        return (op == ALU_multu) || (op == ALU_mfhi) || (op == ALU_mflo);
    endfunction

endpackage

// File: rtl/multu_step.sv
// rtl/multu_step.sv - one combinational shift-add iteration of the unsigned multiply
module multu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] prod_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    // Add the shifted multiplicand when the current multiplier bit is set;
    // the sum never exceeds 2*WIDTH bits so the wrap is never exercised
    always_comb begin
        prod_nxt   = mplier[0] ? (prod + mcand) : prod;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

endmodule

// File: rtl/multu_hilo.sv
// rtl/multu_hilo.sv - sequential MULTU unit with HI/LO registers, MFHI/MFLO reads and stall
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [5:0]       ALUOperation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 start;
    logic                 finish;

    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;

    logic [2*WIDTH-1:0]   prod_nxt;
    logic [2*WIDTH-1:0]   mcand_nxt;
    logic [WIDTH-1:0]     mplier_nxt;

    multu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prod      (prod),
        .mcand     (mcand),
        .mplier    (mplier),
        .prod_nxt  (prod_nxt),
        .mcand_nxt (mcand_nxt),
        .mplier_nxt(mplier_nxt)
    );

    // Next state: accept MULTU only from IDLE, leave RUN after the last iteration
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (en && (ALUOperation == ALU_multu)) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: load operands on start, iterate in RUN, commit HI/LO on the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (start) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
            end else if (state == RUN) begin
                prod   <= prod_nxt;
                mcand  <= mcand_nxt;
                mplier <= mplier_nxt;
                cnt    <= cnt + 1'b1;
                if (finish) begin
                    hi   <= prod_nxt[2*WIDTH-1:WIDTH];
                    lo   <= prod_nxt[WIDTH-1:0];
                    busy <= 1'b0;
                end
            end
        end
    end

    // Read mux: HI/LO are only visible when no multiply is in flight
    always_comb begin
        dataOut = '0;
        if (en && !busy) begin
            case (ALUOperation)
                ALU_mfhi: dataOut = hi;
                ALU_mflo: dataOut = lo;
                default:  dataOut = '0;
            endcase
        end
    end

    // Hold control while a HI/LO-related op arrives during a multiply
    always_comb begin
        stall = en && busy && is_hilo_op(ALUOperation);
    end

endmodule

// File: tb/tb_multu_hilo.sv
// tb/tb_multu_hilo.sv - self-checking bench for multu_hilo
module tb_multu_hilo;
    import multu_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] dout;
    logic        busy;
    logic        done;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    multu_hilo #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ALUOperation(op),
        .a           (a),
        .b           (b),
        .dataOut     (dout),
        .busy        (busy),
        .done        (done),
        .stall       (stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a multiply completes 32 edges after acceptance with the full product
    logic        m_busy;
    logic        m_done;
    int          m_left;
    logic [63:0] m_prod;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_prod <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_hi   <= m_prod[63:32];
                    m_lo   <= m_prod[31:0];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (en && op == ALU_multu) begin
                m_busy <= 1'b1;
                m_left <= 32;
                m_prod <= {32'b0, a} * {32'b0, b};
            end
        end
    end

    function automatic logic [31:0] exp_dout();
        if (en && !m_busy) begin
            if (op == ALU_mfhi) return m_hi;
            if (op == ALU_mflo) return m_lo;
        end
        return 32'h0;
    endfunction

    function automatic logic exp_stall();
        return en && m_busy && (op == ALU_multu || op == ALU_mfhi || op == ALU_mflo);
    endfunction

    // Every cycle after the first reset edge, outputs must match the model
    always @(negedge clk) begin
        if (armed) begin
            check("cyc_dataOut", dout, exp_dout());
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_stall", stall, exp_stall());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_mult(input logic [31:0] x, input logic [31:0] y);
        en = 1'b1;
        op = ALU_multu;
        a  = x;
        b  = y;
        tick();
        en = 1'b0;
        op = ALU_add;
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic wait_done(output int bc, output int dc);
        bit ok;
        bc = 0;
        dc = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc++;
                ok = 1'b1;
                break;
            end
        end
        check("done_within_bound", ok, 1'b1);
    endtask

    task automatic read(input logic [5:0] o, input logic [31:0] exp, input string name);
        en = 1'b1;
        op = o;
        @(negedge clk);
        check(name, dout, exp);
        tick();
        en = 1'b0;
        op = ALU_add;
    endtask

    initial begin
        int bc;
        int dc;
        int sc;
        rst = 1'b1;
        en  = 1'b0;
        op  = ALU_add;
        a   = '0;
        b   = '0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        tick();
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        tick();
        rst = 1'b0;
        read(ALU_mflo, 32'h0, "reset_lo");

        // Basic 3*5
        start_mult(32'd3, 32'd5);
        wait_done(bc, dc);
        check("basic_busy_cycles", bc, 32);
        tick();
        @(negedge clk);
        check("basic_done_once", done, 1'b0);
        tick();
        read(ALU_mfhi, 32'h0000_0000, "basic_hi");
        read(ALU_mflo, 32'h0000_000F, "basic_lo");
        en = 1'b0;
        op = ALU_mflo;
        @(negedge clk);
        check("mflo_en0", dout, 32'h0);
        tick();

        // Max operands
        start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, dc);
        tick();
        read(ALU_mfhi, 32'hFFFF_FFFE, "max_hi");
        read(ALU_mflo, 32'h0000_0001, "max_lo");

        // Early MFHI stalls until the done cycle
        start_mult(32'h0001_0000, 32'h0001_0000);
        tick();
        en = 1'b1;
        op = ALU_mfhi;
        sc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            sc++;
            check("stall_data_zero", dout, 32'h0);
        end
        check("stall_cycles", sc, 31);
        check("stall_release_hi", dout, 32'h0000_0001);
        check("stall_release_done", done, 1'b1);
        tick();
        en = 1'b0;
        read(ALU_mflo, 32'h0, "stall_lo");

        // Reset mid-operation
        start_mult(32'd7, 32'd9);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("abort_no_done", dc, 0);
        tick();
        read(ALU_mfhi, 32'h0, "abort_hi");
        read(ALU_mflo, 32'h0, "abort_lo");
        start_mult(32'd2, 32'd4);
        wait_done(bc, dc);
        tick();
        read(ALU_mflo, 32'd8, "after_abort_lo");

        // 6*7 alone
        start_mult(32'd6, 32'd7);
        wait_done(bc, dc);
        tick();
        read(ALU_mflo, 32'd42, "six_seven_lo");

        // Back-to-back: second MULTU presented in the done cycle
        start_mult(32'd6, 32'd7);
        wait_done(bc, dc);
        #2;
        en = 1'b1;
        op = ALU_multu;
        a  = 32'h8000_0000;
        b  = 32'd2;
        tick();
        en = 1'b0;
        op = ALU_add;
        wait_done(bc, dc);
        check("b2b_busy_cycles", bc, 32);
        tick();
        read(ALU_mfhi, 32'h0000_0001, "b2b_hi");
        read(ALU_mflo, 32'h0000_0000, "b2b_lo");

        // Ignored op while busy, multiply by zero still takes full length
        start_mult(32'd0, 32'h1234);
        en = 1'b1;
        op = ALU_add;
        @(negedge clk);
        check("add_no_stall", stall, 1'b0);
        check("zero_busy", busy, 1'b1);
        tick();
        en = 1'b0;
        wait_done(bc, dc);
        check("zero_busy_rest", bc, 31);
        tick();
        read(ALU_mfhi, 32'h0, "zero_hi");
        read(ALU_mflo, 32'h0, "zero_lo");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
- Sequential unsigned multiply unit with architectural HI/LO registers.
- Sits directly downstream of the ALU control unit and consumes its 6-bit ALUOperation code.
- Executes MULTU as a 32-iteration shift-add operation, and serves MFHI/MFLO reads.
- Produces a stall request to the control path while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each, product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  ALUOperation, a, b are valid this cycle.
- ALUOperation  input  6  code from ALU control: 6'b011001 MULTU, 6'b010000 MFHI, 6'b010010 MFLO; all other codes are ignored.
- a  input  WIDTH  multiplicand (rs).
- b  input  WIDTH  multiplier (rt).
- dataOut  output  WIDTH  MFHI/MFLO result; combinational.
- busy  output  1  multiply in progress; registered.
- done  output  1  one-cycle pulse when HI/LO are updated; registered.
- stall  output  1  control must hold the current instruction; combinational.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - HI=0, LO=0, busy=0, done=0.
  - Counter and working registers are cleared.
  - Overrides everything, including a multiply in progress, which is aborted with no HI/LO write.
- FSM states: IDLE, RUN.
- Start: IDLE with en=1 and op=MULTU. At edge k:
  - mcand <= {0, a} (2*WIDTH bits).
  - mplier <= b.
  - prod <= 0.
  - cnt <= 0.
  - busy <= 1.
  - Go to RUN.
- RUN, each edge:
  - if mplier[0], prod <= prod + mcand; addition is modulo 2*WIDTH, and no overflow is possible.
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - cnt <= cnt + 1.
- Completion: on the RUN edge where cnt == WIDTH-1 (edge k+WIDTH):
  - {HI, LO} <= final product, including that edge's partial add.
  - busy <= 0, done <= 1 for exactly one cycle.
  - Go to IDLE.
- Iteration count is fixed at WIDTH; there is no early termination, even for zero operands.
- Latency: HI/LO hold the new value after edge k+WIDTH (32 cycles after acceptance).
- MFHI/MFLO:
  - dataOut = HI for MFHI, LO for MFLO, when en=1 and busy=0.
  - Otherwise dataOut = 0.
- Stall:
  - stall = en & busy & (op is MULTU, MFHI or MFLO).
  - Other ops never stall.
  - An op seen while busy is not accepted; control re-presents it until stall drops.
- Hazards:
  - MFHI in the done cycle returns the new HI; there is no forwarding requirement beyond this.
  - MULTU in the done cycle (busy=0) is accepted immediately, giving back-to-back issue.
  - HI/LO are unchanged during RUN; they are written only at completion.
- a/b changes after acceptance have no effect.

Decomposition:
- Shared package:
  - ALU operation codes ALU_multu, ALU_mfhi, ALU_mflo, plus the existing add/sub/and/or/slt/sll codes, shared with the ALU control unit.
  - FSM state encoding (IDLE=0, RUN=1).
- One natural sub-module: multu_step.
  - Combinational single shift-add iteration.
  - Inputs: prod, mcand, mplier.
  - Outputs: next prod, next mcand, next mplier.
  - multu_hilo holds the FSM, counter, HI/LO and read mux.

Test Plan:
- Basic multiply: rst for 2 cycles, then MULTU a=3 b=5. Required: busy=1 for 32 cycles, done pulses once, then MFHI -> 0x00000000 and MFLO -> 0x0000000F.
- Max operands: MULTU a=0xFFFFFFFF b=0xFFFFFFFF. Required: after 32 cycles, HI=0xFFFFFFFE and LO=0x00000001.
- Stall on early read: MULTU a=0x10000 b=0x10000, then MFHI held on the next cycle. Required: stall=1 for 31 cycles, dataOut=0 while stalled, then in the done cycle stall=0 and dataOut=0x00000001 (LO=0).
- Reset mid-operation: MULTU 7*9, assert rst at cycle 10. Required: busy=0, HI=LO=0, no done pulse; a new MULTU 2*4 then gives LO=8.
- Back-to-back issue: MULTU 6*7 followed by MULTU 0x80000000*2 presented in the done cycle. Required: the first gives LO=42; the second is accepted without a gap and gives HI=1, LO=0 after 32 more cycles.
- Ignored ops: ALU_add while busy gives stall=0; MFLO with en=0 gives dataOut=0; MULTU by 0 still takes 32 cycles with HI=LO=0.
